tiny_nn_result_capture: RTL
===========================

// Module: tiny_nn_result_capture
// PURPOSE
//  Downstream of the NN top. Snoops the 16-bit command/data word (cmd_i) and the 8-bit core output (byte_i).
//  Reassembles convolve and accumulate results into 16-bit fp_t words and buffers them in a small FIFO.
//  Results drain over a valid/ready port, so host logic need not sample the byte stream every cycle.
// PARAMETERS
//  FifoDepth     4  result FIFO entries (power of 2, >=2)
//  ConvSkipPairs 2  leading convolve byte pairs discarded as pipeline fill
// PORTS
//  clk_i       in   1   clock
//  rst_ni      in   1   asynchronous active-low reset
//  cmd_i       in   16  word presented to the NN top this cycle
//  byte_i      in   8   NN top data output this cycle
//  res_valid_o out  1   FIFO head valid
//  res_ready_i in   1   consumer accepts head
//  res_data_o  out  16  result word {hi,lo}
//  res_kind_o  out  1   0=convolve result, 1=accumulate result
//  overflow_o  out  1   sticky: a result was dropped on full FIFO
//  drop_cnt_o  out  8   dropped-result count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state CapIdle, FIFO empty, res_valid_o=0, res_data_o=0, res_kind_o=0, overflow_o=0, drop_cnt_o=0.
//  Reset mid-operation discards all partial and buffered results.
//  FSM (next state registered; state, counters and FIFO all async-reset):
//   CapIdle: cmd_i[15:12]==CmdOpConvolve -> CapConvParam, cnt=7.
//    CmdOpAccumulate -> CapAccBias; latch n=cmd_i[7:0]; acc_cnt=1.
//    CmdOpTest -> CapTest. Any other opcode: stay.
//   CapConvParam: cnt--; when cnt==0 -> CapConvExec, phase=0, pair=0.
//   CapConvExec/CapConvEnd: phase toggles every cycle.
//    phase 0: lo<=byte_i. phase 1: push {byte_i,lo}, kind 0, only if pair>=ConvSkipPairs.
//    pair increments on phase 1 and saturates at ConvSkipPairs.
//    In CapConvExec, cmd_i==FPStdNaN -> CapConvEnd, cnt=4.
//    CapConvEnd: cnt-- each cycle; in the cycle cnt==0 -> CapIdle. Capture continues through that final cycle.
//   CapAccBias: one cycle -> CapAccExec.
//   CapAccExec:
//    acc_cnt==0: lo<=byte_i; acc_cnt<=n; set hi_pend.
//    Else: if hi_pend, push {byte_i,lo} kind 1 and clear hi_pend; acc_cnt--.
//     cmd_i==FPStdNaN -> CapAccEnd1.
//   CapAccEnd1: lo<=byte_i -> CapAccEnd2.
//   CapAccEnd2: push {byte_i,lo} kind 1 -> CapIdle.
//   CapTest: ignore everything; cmd_i==16'h0000 -> CapIdle. Host ends every test sequence with one zero word.
//  Push latency: a pushed word is visible on res_valid_o the cycle after its high byte appears on byte_i.
//  FIFO: first-word-fall-through; res_data_o/res_kind_o are stable while res_valid_o=1 && !res_ready_i.
//   Pop when res_valid_o && res_ready_i.
//   Simultaneous push+pop when full: accepted, no drop.
//   Push on full without pop: word dropped; overflow_o<=1 (sticky until reset).
//   Pop on empty: no effect.
//  Counters wrap mod 2^8, except drop_cnt_o, which saturates at 8'hff.
// CONFIGURATION
//  `TINY_NN_CAPTURE_STATS_EN defined: drop_cnt_o counts dropped pushes (saturating).
//  Not defined: drop_cnt_o tied to 0 and no counter flops exist. overflow_o is always present.
// STRUCTURE
//  tiny_nn_pkg additions: res_kind_e {ResConv=1'b0, ResAcc=1'b1};
//   res_word_t packed struct {res_kind_e kind; fp_t data}. Reuse existing fp_t, CmdOp*, FPStdNaN.
//  FSM state enum stays local to this module.
//  Sub-module tiny_nn_res_fifo: parameterised FWFT FIFO of res_word_t with push/full/pop/empty.
// TESTING
//  1. Convolve: 8 param words, then 6 exec words with byte_i pattern lo=8'h11*k, hi=8'h22*k, then NaN.
//     -> first 2 pairs skipped; remaining pairs emerge as {22k,11k}, kind 0, in order.
//  2. Accumulate n=2, byte_i low 8'h34 at acc_cnt==0, next 8'h12, then NaN.
//     -> 16'h1234 kind 1, plus the End1/End2 word.
//  3. res_ready_i=0 for a whole convolve producing 6 results, FifoDepth=4.
//     -> 4 held, overflow_o=1, drop_cnt_o=2 (with macro; 0 without).
//  4. FIFO full, push and pop in the same cycle -> no drop, occupancy unchanged, order kept.
//  5. Test command 16'hF1_03 followed by words with convolve opcode, then 16'h0000.
//     -> no pushes; the next convolve is decoded normally.
//  6. rst_ni asserted mid-CapAccExec with 2 words buffered.
//     -> res_valid_o=0 immediately; after release, the next accumulate captures cleanly.

Source files
------------

// File: rtl/tiny_nn_pkg.sv
// tiny_nn_pkg: shared types and constants for the tiny NN block.
//  fp_t        16-bit floating-point word carried on the command/data bus
//  CmdOp*      opcodes decoded from cmd[15:12]
//  FPStdNaN    standard quiet NaN, used by the host as an end-of-stream marker
//  res_kind_e  origin of a captured result (convolve / accumulate)
//  res_word_t  captured result as stored in the result FIFO
package tiny_nn_pkg;

  typedef logic [15:0] fp_t;

  localparam logic [3:0] CmdOpNop        = 4'h0;
  localparam logic [3:0] CmdOpConvolve   = 4'h2;
  localparam logic [3:0] CmdOpAccumulate = 4'h3;
  localparam logic [3:0] CmdOpTest       = 4'hF;

  localparam fp_t FPStdNaN = 16'h7E00;

  typedef enum logic {
    ResConv = 1'b0,
    ResAcc  = 1'b1
  } res_kind_e;

  typedef struct packed {
    res_kind_e kind;
    fp_t       data;
  } res_word_t;

  function automatic logic [3:0] cmd_opcode(input fp_t cmd);
    return cmd[15:12];
  endfunction

endpackage

// File: rtl/tiny_nn_res_fifo.sv
// tiny_nn_res_fifo: first-word-fall-through FIFO of res_word_t.
//  clk_i/rst_ni  clock, asynchronous active-low reset (clears storage too)
//  push_i/data_i write request and word; accepted when not full, or when
//                full and a pop happens in the same cycle
//  full_o        FIFO holds Depth words
//  pop_i         remove head; ignored when empty
//  empty_o       no words held
//  data_o        current head word (all-zero after reset)
// Depth must be a power of two, >= 2.
module tiny_nn_res_fifo
  import tiny_nn_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  res_word_t data_i,
  output logic      full_o,
  input  logic      pop_i,
  output logic      empty_o,
  output res_word_t data_o
);

  localparam int unsigned AW = $clog2(Depth);

  res_word_t        r_mem [Depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign full_o    = (r_count == (AW+1)'(Depth));
  assign empty_o   = (r_count == '0);
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign data_o    = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tiny_nn_result_capture.sv
// tiny_nn_result_capture: snoops the NN top command word and output byte,
// reassembles convolve / accumulate results into 16-bit words and buffers
// them in a FWFT FIFO drained over a valid/ready port.
//  clk_i        clock
//  rst_ni       asynchronous active-low reset
//  cmd_i        word presented to the NN top this cycle
//  byte_i       NN top data output this cycle
//  res_valid_o  FIFO head valid
//  res_ready_i  consumer accepts head
//  res_data_o   result word {hi,lo}
//  res_kind_o   0 = convolve result, 1 = accumulate result
//  overflow_o   sticky: a result was dropped on a full FIFO
//  drop_cnt_o   saturating dropped-result count
// Build option: define TINY_NN_CAPTURE_STATS_EN to implement drop_cnt_o;
// otherwise it is tied to zero.
module tiny_nn_result_capture
  import tiny_nn_pkg::*;
#(
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned ConvSkipPairs = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] cmd_i,
  input  logic [7:0]  byte_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_data_o,
  output logic        res_kind_o,
  output logic        overflow_o,
  output logic [7:0]  drop_cnt_o
);

  typedef enum logic [3:0] {
    CapIdle, CapConvParam, CapConvExec, CapConvEnd,
    CapAccBias, CapAccExec, CapAccEnd1, CapAccEnd2, CapTest
  } cap_state_e;

  cap_state_e r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_acc_cnt;
  logic [7:0] r_n;
  logic [7:0] r_lo;
  logic [7:0] r_pair;
  logic       r_phase;
  logic       r_hi_pend;
  logic       r_overflow;

  logic       w_push;
  res_word_t  w_push_word;
  res_word_t  w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_drop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= CapIdle;
      r_cnt     <= '0;
      r_acc_cnt <= '0;
      r_n       <= '0;
      r_lo      <= '0;
      r_pair    <= '0;
      r_phase   <= 1'b0;
      r_hi_pend <= 1'b0;
    end else begin
      unique case (r_state)
        CapIdle: begin
          r_hi_pend <= 1'b0;
          case (cmd_opcode(cmd_i))
            CmdOpConvolve: begin
              r_state <= CapConvParam;
              r_cnt   <= 8'd7;
            end
            CmdOpAccumulate: begin
              r_state   <= CapAccBias;
              r_n       <= cmd_i[7:0];
              r_acc_cnt <= 8'd1;
            end
            CmdOpTest: r_state <= CapTest;
            default: ;
          endcase
        end
        CapConvParam: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == '0) begin
            r_state <= CapConvExec;
            r_phase <= 1'b0;
            r_pair  <= '0;
          end
        end
        // Byte capture runs identically in Exec and End; only the exit differs.
        CapConvExec, CapConvEnd: begin
          r_phase <= ~r_phase;
          if (!r_phase) r_lo <= byte_i;
          else if (r_pair < 8'(ConvSkipPairs)) r_pair <= r_pair + 8'd1;
          if (r_state == CapConvExec) begin
            if (cmd_i == FPStdNaN) begin
              r_state <= CapConvEnd;
              r_cnt   <= 8'd4;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == '0) r_state <= CapIdle;
          end
        end
        CapAccBias: r_state <= CapAccExec;
        CapAccExec: begin
          if (r_acc_cnt == '0) begin
            r_lo      <= byte_i;
            r_acc_cnt <= r_n;
            r_hi_pend <= 1'b1;
          end else begin
            r_hi_pend <= 1'b0;
            r_acc_cnt <= r_acc_cnt - 8'd1;
            if (cmd_i == FPStdNaN) r_state <= CapAccEnd1;
          end
        end
        CapAccEnd1: begin
          r_lo    <= byte_i;
          r_state <= CapAccEnd2;
        end
        CapAccEnd2: r_state <= CapIdle;
        CapTest: if (cmd_i == 16'h0000) r_state <= CapIdle;
        default: r_state <= CapIdle;
      endcase
    end
  end

  // High byte arrives on byte_i in the push cycle, so the word is formed
  // combinationally and written at the same edge.
  always_comb begin
    w_push           = 1'b0;
    w_push_word.kind = ResConv;
    w_push_word.data = {byte_i, r_lo};
    unique case (r_state)
      CapConvExec, CapConvEnd: w_push = r_phase && (r_pair >= 8'(ConvSkipPairs));
      CapAccExec: begin
        w_push           = (r_acc_cnt != '0) && r_hi_pend;
        w_push_word.kind = ResAcc;
      end
      CapAccEnd2: begin
        w_push           = 1'b1;
        w_push_word.kind = ResAcc;
      end
      default: ;
    endcase
  end

  assign w_pop  = res_ready_i & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  tiny_nn_res_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_push_word),
    .full_o  (w_full),
    .pop_i   (w_pop),
    .empty_o (w_empty),
    .data_o  (w_head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef TINY_NN_CAPTURE_STATS_EN
  logic [7:0] r_drop_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 8'hff)) r_drop_cnt <= r_drop_cnt + 8'd1;
  end
  assign drop_cnt_o = r_drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

  assign res_valid_o = ~w_empty;
  assign res_data_o  = w_head.data;
  assign res_kind_o  = w_head.kind;
  assign overflow_o  = r_overflow;

endmodule
